// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file widths and writeback request type
package regfile_pkg;
    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot arbiter, pointer moves only on a grant
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic          found;
    int            idx;

    // Search starts just after the last winner so every requester rotates to the top.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && en && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= PW'(N - 1);
        end else if (en && |grant) begin
            for (int i = 0; i < N; i++) begin
                if (grant[i]) begin
                    ptr <= PW'(i);
                end
            end
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register-file write port among writeback sources
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = regfile_pkg::XLEN,
    parameter int REG_AW  = regfile_pkg::REG_AW
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*REG_AW-1:0]        req_rd,
    input  logic [NUM_REQ*XLEN-1:0]          req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic                             wb_hold,
    output logic                             RegWrite,
    output logic [REG_AW-1:0]                rd,
    output logic [XLEN-1:0]                  wd,
    output logic [regfile_pkg::NUM_REGS-1:0] pending_mask
);
    import regfile_pkg::*;

    logic [NUM_REQ-1:0] grant;
    logic               grant_en;
    logic               accept;
    logic               sel_live;
    logic [REG_AW-1:0]  sel_rd;
    logic [XLEN-1:0]    sel_data;

    // Gating with reset keeps req_ready low for the whole time reset is held.
    assign grant_en  = ~wb_hold & reset;
    assign req_ready = grant;
    assign accept    = |grant;
    assign sel_live  = accept && (sel_rd != '0);

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk   (clk),
        .reset (reset),
        .req   (req_valid),
        .en    (grant_en),
        .grant (grant)
    );

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_rd   = sel_rd   | req_rd[i*REG_AW +: REG_AW];
                sel_data = sel_data | req_data[i*XLEN +: XLEN];
            end
        end
    end

    // x0 writes still consume the slot but never raise the enable or the mask.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWrite     <= 1'b0;
            rd           <= '0;
            wd           <= '0;
            pending_mask <= '0;
        end else begin
            RegWrite     <= sel_live;
            pending_mask <= sel_live ? (NUM_REGS'(1) << sel_rd) : '0;
            if (accept) begin
                rd <= sel_rd;
                wd <= sel_data;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed vector bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [14:0] req_rd;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        wb_hold;
    logic        RegWrite;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [31:0] pending_mask;

    int tests = 0;
    int fails = 0;

    logic [31:0] model [32] = '{default: 32'h0};

    typedef struct {
        logic [2:0]  valid;
        logic [4:0]  rd0, rd1, rd2;
        logic [31:0] d0, d1, d2;
        logic        hold;
        logic [2:0]  ready;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [31:0] mask;
    } vec_t;

    vec_t vecs [25];

    regfile_wb_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_rd       (req_rd),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .wb_hold      (wb_hold),
        .RegWrite     (RegWrite),
        .rd           (rd),
        .wd           (wd),
        .pending_mask (pending_mask)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (RegWrite) model[rd] <= wd;
    end

    function automatic vec_t mk(logic [2:0] v, logic [4:0] r0, logic [31:0] d0,
                                logic [4:0] r1, logic [31:0] d1, logic [4:0] r2,
                                logic [31:0] d2, logic h, logic [2:0] rdy, logic we,
                                logic [4:0] erd, logic [31:0] ewd, logic [31:0] em);
        vec_t t;
        t.valid = v; t.rd0 = r0; t.d0 = d0; t.rd1 = r1; t.d1 = d1;
        t.rd2 = r2; t.d2 = d2; t.hold = h; t.ready = rdy; t.we = we;
        t.rd = erd; t.wd = ewd; t.mask = em;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        req_valid = t.valid;
        req_rd    = {t.rd2, t.rd1, t.rd0};
        req_data  = {t.d2, t.d1, t.d0};
        wb_hold   = t.hold;
    endtask

    initial begin
        //             valid   rd0 d0        rd1 d1            rd2 d2      hold rdy   we rd  wd            mask
        vecs[0]  = mk(3'b010, 0, 0,        5, 32'hDEADBEEF, 0, 0,        0, 3'b010, 0, 0, 0,            32'h0);
        vecs[1]  = mk(3'b000, 0, 0,        0, 0,            0, 0,        0, 3'b000, 1, 5, 32'hDEADBEEF, 32'h20);
        vecs[2]  = mk(3'b000, 0, 0,        0, 0,            0, 0,        0, 3'b000, 0, 0, 0,            32'h0);
        vecs[3]  = mk(3'b111, 1, 32'h101,  2, 32'h202,      3, 32'h303,  0, 3'b100, 0, 0, 0,            32'h0);
        vecs[4]  = mk(3'b111, 1, 32'h101,  2, 32'h202,      3, 32'h303,  0, 3'b001, 1, 3, 32'h303,      32'h8);
        vecs[5]  = mk(3'b111, 1, 32'h101,  2, 32'h202,      3, 32'h303,  0, 3'b010, 1, 1, 32'h101,      32'h2);
        vecs[6]  = mk(3'b111, 1, 32'h101,  2, 32'h202,      3, 32'h303,  0, 3'b100, 1, 2, 32'h202,      32'h4);
        vecs[7]  = mk(3'b111, 1, 32'h101,  2, 32'h202,      3, 32'h303,  0, 3'b001, 1, 3, 32'h303,      32'h8);
        vecs[8]  = mk(3'b111, 1, 32'h101,  2, 32'h202,      3, 32'h303,  0, 3'b010, 1, 1, 32'h101,      32'h2);
        vecs[9]  = mk(3'b000, 0, 0,        0, 0,            0, 0,        0, 3'b000, 1, 2, 32'h202,      32'h4);
        vecs[10] = mk(3'b000, 0, 0,        0, 0,            0, 0,        0, 3'b000, 0, 0, 0,            32'h0);
        vecs[11] = mk(3'b100, 0, 0,        0, 0,            9, 32'h99,   0, 3'b100, 0, 0, 0,            32'h0);
        vecs[12] = mk(3'b101, 7, 32'h11,   0, 0,            7, 32'h22,   0, 3'b001, 1, 9, 32'h99,       32'h200);
        vecs[13] = mk(3'b100, 0, 0,        0, 0,            7, 32'h22,   0, 3'b100, 1, 7, 32'h11,       32'h80);
        vecs[14] = mk(3'b000, 0, 0,        0, 0,            0, 0,        0, 3'b000, 1, 7, 32'h22,       32'h80);
        vecs[15] = mk(3'b001, 0, 32'hFFFF, 0, 0,            0, 0,        0, 3'b001, 0, 0, 0,            32'h0);
        vecs[16] = mk(3'b000, 0, 0,        0, 0,            0, 0,        0, 3'b000, 0, 0, 0,            32'h0);
        vecs[17] = mk(3'b110, 0, 0,        10, 32'hA,       11, 32'hB,   1, 3'b000, 0, 0, 0,            32'h0);
        vecs[18] = mk(3'b110, 0, 0,        10, 32'hA,       11, 32'hB,   1, 3'b000, 0, 0, 0,            32'h0);
        vecs[19] = mk(3'b110, 0, 0,        10, 32'hA,       11, 32'hB,   1, 3'b000, 0, 0, 0,            32'h0);
        vecs[20] = mk(3'b110, 0, 0,        10, 32'hA,       11, 32'hB,   1, 3'b000, 0, 0, 0,            32'h0);
        vecs[21] = mk(3'b110, 0, 0,        10, 32'hA,       11, 32'hB,   0, 3'b010, 0, 0, 0,            32'h0);
        vecs[22] = mk(3'b100, 0, 0,        0, 0,            11, 32'hB,   0, 3'b100, 1, 10, 32'hA,       32'h400);
        vecs[23] = mk(3'b000, 0, 0,        0, 0,            0, 0,        0, 3'b000, 1, 11, 32'hB,       32'h800);
        vecs[24] = mk(3'b000, 0, 0,        0, 0,            0, 0,        0, 3'b000, 0, 0, 0,            32'h0);

        reset     = 1'b0;
        req_valid = 3'b111;
        req_rd    = {5'd3, 5'd2, 5'd1};
        req_data  = {32'h3, 32'h2, 32'h1};
        wb_hold   = 1'b0;
        #12;
        chk("reset_ready", req_ready, 3'b000);
        chk("reset_regwrite", RegWrite, 1'b0);
        chk("reset_rd", rd, 5'd0);
        chk("reset_wd", wd, 32'h0);
        chk("reset_mask", pending_mask, 32'h0);
        #8 req_valid = 3'b000;
        #2 reset = 1'b1;

        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1 drive(vecs[i]);
            #4;
            chk($sformatf("v%0d_ready", i), req_ready, vecs[i].ready);
            chk($sformatf("v%0d_regwrite", i), RegWrite, vecs[i].we);
            chk($sformatf("v%0d_mask", i), pending_mask, vecs[i].mask);
            if (vecs[i].we) begin
                chk($sformatf("v%0d_rd", i), rd, vecs[i].rd);
                chk($sformatf("v%0d_wd", i), wd, vecs[i].wd);
            end
        end

        // Stage a write, then pull reset in the middle of the cycle it is visible.
        @(posedge clk);
        #1 req_valid = 3'b010;
        req_rd    = {5'd0, 5'd4, 5'd0};
        req_data  = {32'h0, 32'h44, 32'h0};
        #2 chk("mid_ready", req_ready, 3'b010);
        @(posedge clk);
        #1 req_valid = 3'b000;
        #1 chk("mid_staged_we", RegWrite, 1'b1);
        chk("mid_staged_mask", pending_mask, 32'h10);
        #1 reset = 1'b0;
        #1 chk("areset_we", RegWrite, 1'b0);
        chk("areset_mask", pending_mask, 32'h0);
        chk("areset_rd", rd, 5'd0);
        req_valid = 3'b111;
        req_rd    = '0;
        #1 chk("areset_ready", req_ready, 3'b000);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("post_reset_prio", req_ready, 3'b001);
        req_valid = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        chk("model_r7", model[7], 32'h22);
        chk("model_r4_discarded", model[4], 32'h0);
        chk("model_r0", model[0], 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
